// File: rtl/mem_req_tracker.sv
// In-order request/response tracker: queues request addresses, checks responses against the oldest entry.
// Optional MEM_REQ_TRACKER_LATENCY_EN adds per-entry cycle stamps and last/max latency outputs.
module mem_req_tracker #(
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_BITS     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  input  logic                      rsp_valid,
  input  logic [ADDRESS_BITS-1:0]   rsp_addr,
  input  logic                      flush,
  input  logic                      err_clear,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      full,
  output logic                      empty,
  output logic [ADDRESS_BITS-1:0]   head_addr,
  output logic                      err_overflow,
  output logic                      err_underflow,
  output logic                      err_mismatch,
  output logic [ADDRESS_BITS-1:0]   err_addr,
  output logic [CNT_BITS-1:0]       req_count,
  output logic [CNT_BITS-1:0]       rsp_count
`ifdef MEM_REQ_TRACKER_LATENCY_EN
  ,
  output logic [CNT_BITS-1:0]       last_latency,
  output logic [CNT_BITS-1:0]       max_latency
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDRESS_BITS-1:0] mem_q [DEPTH];
  logic [ADDRESS_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        outstanding_q, outstanding_d;
  logic                    full_q, full_d;
  logic                    empty_q, empty_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    err_underflow_q, err_underflow_d;
  logic                    err_mismatch_q, err_mismatch_d;
  logic [ADDRESS_BITS-1:0] err_addr_q, err_addr_d;
  logic [CNT_BITS-1:0]     req_count_q, req_count_d;
  logic [CNT_BITS-1:0]     rsp_count_q, rsp_count_d;

  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [ADDRESS_BITS-1:0] head_c;
  logic                    pop_c;
  logic                    match_c;
  logic                    mism_c;
  logic                    push_c;
  logic                    new_ovf_c;
  logic                    new_unf_c;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign head_c = empty_q ? '0 : mem_q[rd_idx];

  // Event decode; flush suppresses every queue action and error in its cycle.
  assign pop_c     = !flush && rsp_valid && !empty_q;
  assign match_c   = pop_c && (rsp_addr == head_c);
  assign mism_c    = pop_c && (rsp_addr != head_c);
  assign new_unf_c = !flush && rsp_valid && empty_q;
  assign push_c    = !flush && req_valid && (!full_q || pop_c);
  assign new_ovf_c = !flush && req_valid && full_q && !pop_c;

  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    err_mismatch_d  = err_mismatch_q;
    err_addr_d      = err_addr_q;
    req_count_d     = req_count_q;
    rsp_count_d     = rsp_count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_c) begin
        mem_d[wr_idx] = req_addr;
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
        req_count_d   = req_count_q + CNT_BITS'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (match_c) begin
        rsp_count_d = rsp_count_q + CNT_BITS'(1);
      end

      // Sticky flags: a new error in the clearing cycle still sets.
      err_overflow_d  = (err_overflow_q  && !err_clear) || new_ovf_c;
      err_underflow_d = (err_underflow_q && !err_clear) || new_unf_c;
      err_mismatch_d  = (err_mismatch_q  && !err_clear) || mism_c;
      if (mism_c && (!err_mismatch_q || err_clear)) begin
        err_addr_d = rsp_addr;
      end else if (err_clear) begin
        err_addr_d = '0;
      end
    end

    outstanding_d = wr_ptr_d - rd_ptr_d;
    full_d        = (outstanding_d == PTR_W'(DEPTH));
    empty_d       = (outstanding_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      outstanding_q   <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_mismatch_q  <= 1'b0;
      err_addr_q      <= '0;
      req_count_q     <= '0;
      rsp_count_q     <= '0;
    end else begin
      mem_q           <= mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      outstanding_q   <= outstanding_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_mismatch_q  <= err_mismatch_d;
      err_addr_q      <= err_addr_d;
      req_count_q     <= req_count_d;
      rsp_count_q     <= rsp_count_d;
    end
  end

`ifdef MEM_REQ_TRACKER_LATENCY_EN
  logic [CNT_BITS-1:0] stamp_q [DEPTH];
  logic [CNT_BITS-1:0] stamp_d [DEPTH];
  logic [CNT_BITS-1:0] now_q, now_d;
  logic [CNT_BITS-1:0] last_latency_q, last_latency_d;
  logic [CNT_BITS-1:0] max_latency_q, max_latency_d;
  logic [CNT_BITS-1:0] latency_c;
  logic [CNT_BITS-1:0] max_base_c;

  assign latency_c = now_q - stamp_q[rd_idx];

  // Stamps are only meaningful between push and pop; a flush orphans them via the pointer reset.
  always_comb begin
    stamp_d        = stamp_q;
    now_d          = now_q + CNT_BITS'(1);
    last_latency_d = last_latency_q;
    max_base_c     = (err_clear && !flush) ? '0 : max_latency_q;
    max_latency_d  = max_base_c;
    if (push_c) begin
      stamp_d[wr_idx] = now_q;
    end
    if (match_c) begin
      last_latency_d = latency_c;
      if (latency_c > max_base_c) begin
        max_latency_d = latency_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) stamp_q[i] <= '0;
      now_q          <= '0;
      last_latency_q <= '0;
      max_latency_q  <= '0;
    end else begin
      stamp_q        <= stamp_d;
      now_q          <= now_d;
      last_latency_q <= last_latency_d;
      max_latency_q  <= max_latency_d;
    end
  end

  assign last_latency = last_latency_q;
  assign max_latency  = max_latency_q;
`endif

  assign outstanding   = outstanding_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign head_addr     = head_c;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_mismatch  = err_mismatch_q;
  assign err_addr      = err_addr_q;
  assign req_count     = req_count_q;
  assign rsp_count     = rsp_count_q;

endmodule

// File: tb/tb_mem_req_tracker.sv
// Bench for mem_req_tracker: directed vector table plus a random phase checked against a queue model.
module tb_mem_req_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        rsp_valid;
  logic [11:0] rsp_addr;
  logic        flush;
  logic        err_clear;
  logic [2:0]  outstanding;
  logic        full;
  logic        empty;
  logic [11:0] head_addr;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_mismatch;
  logic [11:0] err_addr;
  logic [31:0] req_count;
  logic [31:0] rsp_count;
`ifdef MEM_REQ_TRACKER_LATENCY_EN
  logic [31:0] last_latency;
  logic [31:0] max_latency;
`endif

  mem_req_tracker #(.ADDRESS_BITS(12), .DEPTH(4), .CNT_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .flush(flush), .err_clear(err_clear),
    .outstanding(outstanding), .full(full), .empty(empty), .head_addr(head_addr),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_mismatch(err_mismatch), .err_addr(err_addr),
    .req_count(req_count), .rsp_count(rsp_count)
`ifdef MEM_REQ_TRACKER_LATENCY_EN
    , .last_latency(last_latency), .max_latency(max_latency)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, rq;
    logic [11:0] ra;
    logic        rs;
    logic [11:0] sa;
    logic        fl, ec;
    logic [2:0]  o;
    logic        f, e;
    logic [11:0] h;
    logic        ov, un, mi;
    logic [11:0] ea;
    logic [31:0] rc, sc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(int rst, int rq, int ra, int rs, int sa, int fl, int ec,
                              int o, int f, int e, int h, int ov, int un, int mi, int ea,
                              int rc, int sc);
    vec_t v;
    v.rst = 1'(rst); v.rq = 1'(rq); v.ra = 12'(ra); v.rs = 1'(rs); v.sa = 12'(sa);
    v.fl = 1'(fl); v.ec = 1'(ec); v.o = 3'(o); v.f = 1'(f); v.e = 1'(e); v.h = 12'(h);
    v.ov = 1'(ov); v.un = 1'(un); v.mi = 1'(mi); v.ea = 12'(ea);
    v.rc = 32'(rc); v.sc = 32'(sc);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare once the edge has produced the outputs.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    reset = v.rst; req_valid = v.rq; req_addr = v.ra;
    rsp_valid = v.rs; rsp_addr = v.sa; flush = v.fl; err_clear = v.ec;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("outstanding", idx, 32'(outstanding), 32'(e.o));
    chk("full", idx, 32'(full), 32'(e.f));
    chk("empty", idx, 32'(empty), 32'(e.e));
    chk("head_addr", idx, 32'(head_addr), 32'(e.h));
    chk("err_overflow", idx, 32'(err_overflow), 32'(e.ov));
    chk("err_underflow", idx, 32'(err_underflow), 32'(e.un));
    chk("err_mismatch", idx, 32'(err_mismatch), 32'(e.mi));
    chk("err_addr", idx, 32'(err_addr), 32'(e.ea));
    chk("req_count", idx, req_count, e.rc);
    chk("rsp_count", idx, rsp_count, e.sc);
  endtask

  // Reference model state for the random phase.
  logic [11:0] mq[$];
  logic        m_ov, m_un, m_mi;
  logic [11:0] m_ea;
  logic [31:0] m_rc, m_sc;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_valid = 1'b0;
    rsp_addr = '0; flush = 1'b0; err_clear = 1'b0;

    //             rst rq ra      rs sa      fl ec  o  f  e  h      ov un mi ea     rc sc
    tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 'h100,  0, 0,      0, 0,  1, 0, 0, 'h100, 0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 'h104,  0, 0,      0, 0,  2, 0, 0, 'h100, 0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 1, 'h108,  0, 0,      0, 0,  3, 0, 0, 'h100, 0, 0, 0, 0,     3, 0));
    tbl.push_back(mk(0, 0, 0,      1, 'h100,  0, 0,  2, 0, 0, 'h104, 0, 0, 0, 0,     3, 1));
    tbl.push_back(mk(0, 0, 0,      1, 'h104,  0, 0,  1, 0, 0, 'h108, 0, 0, 0, 0,     3, 2));
    tbl.push_back(mk(0, 0, 0,      1, 'h108,  0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     3, 3));
    tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 'h0,    0, 0,      0, 0,  1, 0, 0, 'h0,   0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 'h4,    0, 0,      0, 0,  2, 0, 0, 'h0,   0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 1, 'h8,    0, 0,      0, 0,  3, 0, 0, 'h0,   0, 0, 0, 0,     3, 0));
    tbl.push_back(mk(0, 1, 'hC,    0, 0,      0, 0,  4, 1, 0, 'h0,   0, 0, 0, 0,     4, 0));
    tbl.push_back(mk(0, 1, 'h10,   0, 0,      0, 0,  4, 1, 0, 'h0,   1, 0, 0, 0,     4, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0,      0, 1,  4, 1, 0, 'h0,   0, 0, 0, 0,     4, 0));
    tbl.push_back(mk(0, 1, 'h10,   1, 'h0,    0, 0,  4, 1, 0, 'h4,   0, 0, 0, 0,     5, 1));
    tbl.push_back(mk(0, 0, 0,      1, 'h4,    0, 0,  3, 0, 0, 'h8,   0, 0, 0, 0,     5, 2));
    tbl.push_back(mk(0, 0, 0,      1, 'h8,    0, 0,  2, 0, 0, 'hC,   0, 0, 0, 0,     5, 3));
    tbl.push_back(mk(0, 0, 0,      1, 'hC,    0, 0,  1, 0, 0, 'h10,  0, 0, 0, 0,     5, 4));
    tbl.push_back(mk(0, 0, 0,      1, 'h10,   0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     5, 5));
    tbl.push_back(mk(0, 1, 'h20,   0, 0,      0, 0,  1, 0, 0, 'h20,  0, 0, 0, 0,     6, 5));
    tbl.push_back(mk(0, 0, 0,      1, 'h24,   0, 0,  0, 0, 1, 0,     0, 0, 1, 'h24,  6, 5));
    tbl.push_back(mk(0, 0, 0,      0, 0,      0, 1,  0, 0, 1, 0,     0, 0, 0, 0,     6, 5));
    tbl.push_back(mk(0, 1, 'h30,   1, 'h50,   0, 0,  1, 0, 0, 'h30,  0, 1, 0, 0,     7, 5));
    tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 'h34,   0, 0,      0, 0,  1, 0, 0, 'h34,  0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 'h38,   0, 0,      0, 0,  2, 0, 0, 'h34,  0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 1, 'h3C,   0, 0,      0, 0,  3, 0, 0, 'h34,  0, 0, 0, 0,     3, 0));
    tbl.push_back(mk(0, 1, 'h40,   1, 'h34,   1, 0,  0, 0, 1, 0,     0, 0, 0, 0,     3, 0));
    tbl.push_back(mk(0, 1, 'h44,   0, 0,      0, 0,  1, 0, 0, 'h44,  0, 0, 0, 0,     4, 0));
    tbl.push_back(mk(0, 1, 'h48,   0, 0,      0, 0,  2, 0, 0, 'h44,  0, 0, 0, 0,     5, 0));
    tbl.push_back(mk(1, 1, 'h4C,   1, 'h44,   0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,      1, 'h1,    0, 1,  0, 0, 1, 0,     0, 1, 0, 0,     0, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0,      0, 1,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));
    tbl.push_back(mk(0, 1, 'h60,   0, 0,      0, 0,  1, 0, 0, 'h60,  0, 0, 0, 0,     1, 0));
    tbl.push_back(mk(0, 1, 'h64,   0, 0,      0, 0,  2, 0, 0, 'h60,  0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 0, 0,      1, 'h61,   0, 0,  1, 0, 0, 'h64,  0, 0, 1, 'h61,  2, 0));
    tbl.push_back(mk(0, 0, 0,      1, 'h65,   0, 0,  0, 0, 1, 0,     0, 0, 1, 'h61,  2, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0,      0, 1,  0, 0, 1, 0,     0, 0, 0, 0,     2, 0));
    tbl.push_back(mk(0, 0, 0,      1, 'h7,    0, 0,  0, 0, 1, 0,     0, 1, 0, 0,     2, 0));
    tbl.push_back(mk(0, 0, 0,      0, 0,      1, 0,  0, 0, 1, 0,     0, 1, 0, 0,     2, 0));
    tbl.push_back(mk(1, 0, 0,      0, 0,      0, 0,  0, 0, 1, 0,     0, 0, 0, 0,     0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Random traffic starting from the reset state left by the last table row.
    m_ov = 1'b0; m_un = 1'b0; m_mi = 1'b0; m_ea = '0; m_rc = '0; m_sc = '0;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic pop, match, mism, push, nov, nun;
      v.rst = 1'b0;
      v.rq  = 1'($urandom_range(0, 1));
      v.ra  = 12'($urandom);
      v.rs  = 1'($urandom_range(0, 1));
      v.sa  = (mq.size() != 0 && $urandom_range(0, 4) != 0) ? mq[0] : 12'($urandom);
      v.fl  = ($urandom_range(0, 31) == 0);
      v.ec  = ($urandom_range(0, 15) == 0);
      if (v.fl) begin
        mq.delete();
      end else begin
        pop   = v.rs && (mq.size() != 0);
        match = pop && (v.sa == mq[0]);
        mism  = pop && !match;
        nun   = v.rs && (mq.size() == 0);
        push  = v.rq && ((mq.size() < 4) || pop);
        nov   = v.rq && (mq.size() == 4) && !pop;
        if (mism && (!m_mi || v.ec)) m_ea = v.sa;
        else if (v.ec)               m_ea = '0;
        m_ov = (m_ov && !v.ec) || nov;
        m_un = (m_un && !v.ec) || nun;
        m_mi = (m_mi && !v.ec) || mism;
        if (pop) void'(mq.pop_front());
        if (push) begin mq.push_back(v.ra); m_rc++; end
        if (match) m_sc++;
      end
      v.o  = 3'(mq.size());
      v.f  = (mq.size() == 4);
      v.e  = (mq.size() == 0);
      v.h  = (mq.size() != 0) ? mq[0] : 12'h0;
      v.ov = m_ov; v.un = m_un; v.mi = m_mi; v.ea = m_ea;
      v.rc = m_rc; v.sc = m_sc;
      step(v, 1000 + n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
